fsm_cmd_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one downstream mode FSM (3-bit command input, single command channel) between `NREQ` requesters. It grants one requester at a time, captures its command, and presents it on a valid/ack channel. It bounds every transaction with a timeout and recovers deterministically from any illegal internal state. It sits between the requesting agents and the mode FSM's `user_input` port.

---
 rtl/fsm_arb_pkg.sv | 23 ++
 rtl/fsm_cmd_arbiter_rr_pick.sv | 29 ++
 rtl/fsm_cmd_arbiter.sv | 127 ++++++++++++
 tb/tb_fsm_cmd_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fsm_arb_pkg.sv
// Shared types and constants for the command arbiter: state encoding,
// command width, NOP code and error-counter width.
package fsm_arb_pkg;

   localparam int CMD_W     = 3;
   localparam int ERR_CNT_W = 8;

   localparam logic [CMD_W-1:0] CMD_NOP = 3'b000;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_GRANT   = 3'd1,
      ST_ISSUE   = 3'd2,
      ST_RELEASE = 3'd3,
      ST_ABORT   = 3'd4
   } st_t;

   // Index width for NREQ requesters; at least one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fsm_cmd_arbiter_rr_pick.sv
// Rotating-priority encoder: picks the first requester at or after ptr,
// wrapping modulo NREQ. Purely combinational.
module rr_pick
   import fsm_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int PW   = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [PW-1:0]   win,
   output logic            any
);

   // Walk from the farthest candidate back to ptr so the nearest one wins.
   always_comb begin
      win = '0;
      any = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         int idx;
         idx = (int'(ptr) + k) % NREQ;
         if (req[idx]) begin
            win = PW'(idx);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fsm_cmd_arbiter.sv
// Round-robin arbiter feeding one shared command channel to the mode FSM,
// with per-transaction timeout and illegal-state recovery.
module fsm_cmd_arbiter
   import fsm_arb_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [CMD_W*NREQ-1:0] cmd_in,
   output logic [NREQ-1:0]       gnt,
   output logic [CMD_W-1:0]      cmd_out,
   output logic                  cmd_valid,
   input  logic                  cmd_ack,
   output logic                  busy,
   output logic                  err,
   output logic [ERR_CNT_W-1:0]  err_cnt
);

   localparam int PW    = idx_w(NREQ);
   localparam int CNT_W = $clog2(TIMEOUT);

   st_t                  r_state;
   logic [PW-1:0]        r_ptr;
   logic [PW-1:0]        r_sel;
   logic [CNT_W-1:0]     r_cnt;
   logic [NREQ-1:0]      r_gnt;
   logic [CMD_W-1:0]     r_cmd_out;
   logic                 r_cmd_valid;
   logic                 r_err;
   logic [ERR_CNT_W-1:0] r_err_cnt;

   logic [PW-1:0]        w_win;
   logic                 w_any;
   logic [CMD_W-1:0]     w_cmd_sel;
   logic [PW-1:0]        w_ptr_nxt;
   logic [ERR_CNT_W-1:0] w_err_cnt_inc;

   rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_pick (
      .req  (req),
      .ptr  (r_ptr),
      .win  (w_win),
      .any  (w_any)
   );

   assign w_cmd_sel     = cmd_in[CMD_W*r_sel +: CMD_W];
   assign w_ptr_nxt     = (r_sel == PW'(NREQ - 1)) ? '0 : r_sel + 1'b1;
   assign w_err_cnt_inc = (r_err_cnt == '1) ? r_err_cnt : r_err_cnt + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_ptr       <= '0;
         r_sel       <= '0;
         r_cnt       <= '0;
         r_gnt       <= '0;
         r_cmd_out   <= '0;
         r_cmd_valid <= 1'b0;
         r_err       <= 1'b0;
         r_err_cnt   <= '0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_sel   <= w_win;
                  r_gnt   <= NREQ'(1) << w_win;
                  r_state <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               // Capture here; later cmd_in changes are ignored.
               r_cmd_out <= w_cmd_sel;
               if (w_cmd_sel == CMD_NOP) begin
                  r_gnt   <= '0;
                  r_state <= ST_RELEASE;
               end else begin
                  r_cnt       <= '0;
                  r_cmd_valid <= 1'b1;
                  r_state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // Ack on the final counted cycle still wins over timeout.
               if (cmd_ack) begin
                  r_gnt       <= '0;
                  r_cmd_valid <= 1'b0;
                  r_state     <= ST_RELEASE;
               end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                  r_gnt       <= '0;
                  r_cmd_valid <= 1'b0;
                  r_err       <= 1'b1;
                  r_err_cnt   <= w_err_cnt_inc;
                  r_state     <= ST_ABORT;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_RELEASE, ST_ABORT: begin
               r_ptr   <= w_ptr_nxt;
               r_state <= ST_IDLE;
            end
            default: begin
               // Illegal encoding: recover to IDLE, keep ptr, flag it.
               r_gnt       <= '0;
               r_cmd_valid <= 1'b0;
               r_err       <= 1'b1;
               r_err_cnt   <= w_err_cnt_inc;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign gnt       = r_gnt;
   assign cmd_out   = r_cmd_out;
   assign cmd_valid = r_cmd_valid;
   assign busy      = (r_state != ST_IDLE);
   assign err       = r_err;
   assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_fsm_cmd_arbiter.sv
// Directed bench for fsm_cmd_arbiter: round-robin, timeout, NOP reject,
// last-cycle ack, illegal-state recovery and async reset.
module tb_fsm_cmd_arbiter;
   import fsm_arb_pkg::*;

   localparam int NREQ    = 4;
   localparam int TIMEOUT = 16;

   logic                  clk;
   logic                  rst_n;
   logic [NREQ-1:0]       req;
   logic [CMD_W*NREQ-1:0] cmd_in;
   logic [NREQ-1:0]       gnt;
   logic [CMD_W-1:0]      cmd_out;
   logic                  cmd_valid;
   logic                  cmd_ack;
   logic                  busy;
   logic                  err;
   logic [ERR_CNT_W-1:0]  err_cnt;

   logic ack_tie;
   logic ack_drv;

   int n_chk;
   int n_err;

   assign cmd_ack = ack_tie ? cmd_valid : ack_drv;

   fsm_cmd_arbiter #(
      .NREQ      (NREQ),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .cmd_in    (cmd_in),
      .gnt       (gnt),
      .cmd_out   (cmd_out),
      .cmd_valid (cmd_valid),
      .cmd_ack   (cmd_ack),
      .busy      (busy),
      .err       (err),
      .err_cnt   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int w;
      n_chk   = 0;
      n_err   = 0;
      rst_n   = 1'b0;
      req     = '0;
      ack_tie = 1'b0;
      ack_drv = 1'b0;
      // req3=NOP, req2=110, req1=101, req0=011
      cmd_in  = {3'b000, 3'b110, 3'b101, 3'b011};

      step();
      step();
      chk("rst_gnt",     32'(gnt), 0);
      chk("rst_cmd_out", 32'(cmd_out), 0);
      chk("rst_valid",   32'(cmd_valid), 0);
      chk("rst_busy",    32'(busy), 0);
      chk("rst_err",     32'(err), 0);
      chk("rst_err_cnt", 32'(err_cnt), 0);
      rst_n = 1'b1;
      step();

      // Round robin between requesters 0 and 2, ack tied to valid.
      req     = 4'b0101;
      ack_tie = 1'b1;
      for (int i = 0; i < 4; i++) begin
         w = (i % 2 == 0) ? 0 : 2;
         step();
         chk("rr_gnt",       32'(gnt), 32'(1 << w));
         chk("rr_valid_g",   32'(cmd_valid), 0);
         step();
         chk("rr_valid",     32'(cmd_valid), 1);
         chk("rr_cmd",       32'(cmd_out), (w == 0) ? 3 : 6);
         step();
         chk("rr_rel_gnt",   32'(gnt), 0);
         chk("rr_rel_valid", 32'(cmd_valid), 0);
         step();
         chk("rr_idle",      32'(busy), 0);
         if (i == 3) req = '0;
      end
      ack_tie = 1'b0;

      // Ack while idle must be ignored.
      ack_drv = 1'b1;
      step();
      chk("ack_idle_busy", 32'(busy), 0);
      ack_drv = 1'b0;

      // Timeout: requester 1 (ptr=3 wraps to 1), never acked.
      req = 4'b0010;
      step();
      chk("to_gnt", 32'(gnt), 4'b0010);
      req = '0;
      step();
      chk("to_cmd", 32'(cmd_out), 3'b101);
      n = 0;
      while (cmd_valid && n < 40) begin
         n++;
         step();
      end
      chk("to_valid_len", 32'(n), TIMEOUT);
      chk("to_err",       32'(err), 1);
      chk("to_err_cnt",   32'(err_cnt), 1);
      chk("to_abort_gnt", 32'(gnt), 0);
      step();
      chk("to_err_pulse", 32'(err), 0);
      chk("to_idle",      32'(busy), 0);
      chk("to_ptr",       32'(dut.r_ptr), 2);

      // NOP from requester 3: one grant cycle, no valid, ptr wraps to 0.
      req = 4'b1000;
      step();
      chk("nop_gnt",   32'(gnt), 4'b1000);
      chk("nop_valid", 32'(cmd_valid), 0);
      req = '0;
      step();
      chk("nop_rel_gnt",   32'(gnt), 0);
      chk("nop_rel_valid", 32'(cmd_valid), 0);
      chk("nop_rel_busy",  32'(busy), 1);
      step();
      chk("nop_idle", 32'(busy), 0);
      chk("nop_ptr",  32'(dut.r_ptr), 0);

      // Ack on the last allowed ISSUE cycle: release, no abort.
      req = 4'b0010;
      step();
      chk("la_gnt", 32'(gnt), 4'b0010);
      req = '0;
      step();
      for (int i = 0; i < TIMEOUT - 1; i++) step();
      chk("la_valid_last", 32'(cmd_valid), 1);
      ack_drv = 1'b1;
      step();
      ack_drv = 1'b0;
      chk("la_rel_valid", 32'(cmd_valid), 0);
      chk("la_rel_err",   32'(err), 0);
      chk("la_rel_busy",  32'(busy), 1);
      chk("la_err_cnt",   32'(err_cnt), 1);
      step();
      chk("la_idle_err", 32'(err), 0);
      chk("la_idle",     32'(busy), 0);
      chk("la_ptr",      32'(dut.r_ptr), 2);

      // Illegal state 3'b111 forced while idle.
      force dut.r_state = st_t'(3'b111);
      #1;
      release dut.r_state;
      chk("ill_busy", 32'(busy), 1);
      step();
      chk("ill_idle",    32'(busy), 0);
      chk("ill_err",     32'(err), 1);
      chk("ill_gnt",     32'(gnt), 0);
      chk("ill_err_cnt", 32'(err_cnt), 2);
      chk("ill_ptr",     32'(dut.r_ptr), 2);
      step();
      chk("ill_err_pulse", 32'(err), 0);

      // Async reset in the middle of ISSUE (ptr=2 wraps to requester 0).
      req = 4'b0001;
      step();
      chk("ar_gnt", 32'(gnt), 4'b0001);
      step();
      chk("ar_valid", 32'(cmd_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid_drop", 32'(cmd_valid), 0);
      chk("ar_gnt_clr",    32'(gnt), 0);
      chk("ar_busy",       32'(busy), 0);
      chk("ar_cmd_out",    32'(cmd_out), 0);
      chk("ar_err_cnt",    32'(err_cnt), 0);
      step();
      chk("ar_hold_valid", 32'(cmd_valid), 0);
      chk("ar_hold_gnt",   32'(gnt), 0);
      req   = '0;
      rst_n = 1'b1;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
